// File: rtl/iq_dsm_upconverter_pkg.sv
// Shared constants and elaboration-time helpers for the IQ delta-sigma upconverter.
// Holds the default NCO sizes, the derived accumulator width, the quarter-turn
// LUT offset, the dither LFSR parameters and the sine-table generator function.
package iq_dsm_upconverter_pkg;

    localparam int unsigned DEF_WIDTH          = 16;
    localparam int unsigned DEF_LUT_DEPTH      = 256;
    localparam int unsigned DEF_ACC_FRAC_WIDTH = 24;
    localparam int unsigned DEF_ACC_INT_WIDTH  = $clog2(DEF_LUT_DEPTH);
    localparam int unsigned DEF_ACC_WIDTH      = DEF_ACC_INT_WIDTH + DEF_ACC_FRAC_WIDTH;
    localparam int unsigned DEF_QUARTER_TURN   = DEF_LUT_DEPTH / 4;

    localparam int unsigned LFSR_WIDTH = 24;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 24'h000001;

    // round(amp * sin(2*pi*k/depth)); only ever evaluated for localparams.
    // Angle folded into [-pi/2, pi/2] so a short Taylor series is exact to well below 1 LSB.
    function automatic int sin_entry(int k, int depth, int width);
        real pi_r;
        real a;
        real a2;
        real term;
        real s;
        real v;
        pi_r = 3.14159265358979323846;
        a    = 2.0 * pi_r * $itor(k) / $itor(depth);
        if (a > pi_r) a = a - 2.0 * pi_r;
        if (a > pi_r / 2.0) a = pi_r - a;
        else if (a < -pi_r / 2.0) a = -pi_r - a;
        a2   = a * a;
        term = a;
        s    = a;
        for (int n = 1; n < 10; n++) begin
            term = -term * a2 / $itor((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        v = $itor((1 << (width - 1)) - 1) * s;
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

endpackage

// File: rtl/iq_dsm_upconverter_if.sv
// Phase-increment stream (AXI-Stream style valid/ready) into the upconverter.
//   tdata  : unsigned phase increment, ACC_WIDTH bits
//   tvalid : source has a new increment
//   tready : sink accepts (high whenever out of reset)
interface iq_dsm_upconverter_if #(
    parameter int unsigned ACC_WIDTH = 32
) ();
    logic [ACC_WIDTH-1:0] tdata;
    logic                 tvalid;
    logic                 tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/iq_dsm_upconverter_mod.sv
// First-order delta-sigma modulator, advanced once per sample tick.
//   aclk, arst_n : clock, synchronous active-low reset
//   i_en         : sample tick
//   i_sample     : signed NCO sample (pre-scaled here by IN_SHIFT)
//   o_bit        : registered modulator output bit
module mod1_dsm #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned EXT      = 1,
    parameter int unsigned IN_SHIFT = 2
) (
    input  logic                    aclk,
    input  logic                    arst_n,
    input  logic                    i_en,
    input  logic signed [WIDTH-1:0] i_sample,
    output logic                    o_bit
);
    localparam int unsigned VW = WIDTH + 1 + EXT;
    localparam logic signed [VW-1:0] FS_POS = VW'(2 ** (WIDTH - 1));
    localparam logic signed [VW-1:0] FS_NEG = -FS_POS;

    logic signed [VW-1:0] r_v;
    logic signed [VW-1:0] w_x;
    logic signed [VW-1:0] w_fb;
    logic                 w_y;
    logic                 r_bit;

    assign w_x  = VW'($signed(i_sample >>> IN_SHIFT));
    assign w_y  = ~r_v[VW-1];
    assign w_fb = w_y ? FS_POS : FS_NEG;

    // Integrator plus registered quantiser decision.
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            r_v   <= '0;
            r_bit <= 1'b0;
        end else if (i_en) begin
            r_v   <= r_v + w_x - w_fb;
            r_bit <= w_y;
        end
    end

    assign o_bit = r_bit;
endmodule

// File: rtl/iq_dsm_upconverter.sv
// Dithered sine/cosine NCO feeding two first-order delta-sigma modulators whose
// bitstreams are mixed onto an fs/4 carrier as an I, Q, -I, -Q serial pattern.
//   aclk, arst_n      : clock, synchronous active-low reset
//   s_axis_step       : phase-increment stream (slave)
//   dither_enable     : add LFSR dither to the lookup phase
//   i_sample/q_sample : registered cosine / sine samples
//   i_bit/q_bit       : modulator bitstreams
//   data_out          : upconverted serial bit
module iq_dsm_upconverter
    import iq_dsm_upconverter_pkg::*;
#(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned LUT_DEPTH      = DEF_LUT_DEPTH,
    parameter int unsigned ACC_FRAC_WIDTH = DEF_ACC_FRAC_WIDTH,
    parameter int unsigned EXT            = 1,
    parameter int unsigned IN_SHIFT       = 2
) (
    input  logic                    aclk,
    input  logic                    arst_n,
    iq_dsm_upconverter_if.slave     s_axis_step,
    input  logic                    dither_enable,
    output logic signed [WIDTH-1:0] i_sample,
    output logic signed [WIDTH-1:0] q_sample,
    output logic                    i_bit,
    output logic                    q_bit,
    output logic                    data_out
);
    localparam int unsigned ACC_INT_WIDTH = $clog2(LUT_DEPTH);
    localparam int unsigned ACC_WIDTH     = ACC_INT_WIDTH + ACC_FRAC_WIDTH;
    localparam int unsigned QUARTER       = LUT_DEPTH / 4;

    logic [1:0]                r_cnt;
    logic                      w_tick;
    logic                      r_ready;
    logic [ACC_WIDTH-1:0]      r_step;
    logic [ACC_WIDTH-1:0]      r_acc;
    logic [ACC_WIDTH-1:0]      w_dither;
    logic [LFSR_WIDTH-1:0]     r_lfsr;
    logic [ACC_INT_WIDTH-1:0]  w_q_idx;
    logic [ACC_INT_WIDTH-1:0]  w_i_idx;
    logic signed [WIDTH-1:0]   w_lut [LUT_DEPTH];
    logic signed [WIDTH-1:0]   r_i_sample;
    logic signed [WIDTH-1:0]   r_q_sample;
    logic                      w_i_bit;
    logic                      w_q_bit;
    logic                      r_data_out;

    // Sine ROM, fully resolved at elaboration.
    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
        localparam int VAL = sin_entry(k, int'(LUT_DEPTH), int'(WIDTH));
        assign w_lut[k] = WIDTH'(VAL);
    end

    // Align the 24-bit LFSR with the fractional phase field.
    if (ACC_FRAC_WIDTH >= LFSR_WIDTH) begin : g_dith_wide
        assign w_dither = ACC_WIDTH'(r_lfsr) << (ACC_FRAC_WIDTH - LFSR_WIDTH);
    end else begin : g_dith_narrow
        assign w_dither = ACC_WIDTH'(r_lfsr >> (LFSR_WIDTH - ACC_FRAC_WIDTH));
    end

    assign w_tick  = (r_cnt == 2'd3);
    // Dither perturbs only the lookup address; carries may reach the integer part.
    assign w_q_idx = ACC_INT_WIDTH'((r_acc + (dither_enable ? w_dither : '0)) >> ACC_FRAC_WIDTH);
    assign w_i_idx = w_q_idx + ACC_INT_WIDTH'(QUARTER);

    // Frame counter, step capture and handshake.
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_step  <= '0;
        end else begin
            r_cnt   <= r_cnt + 2'd1;
            r_ready <= 1'b1;
            if (s_axis_step.tvalid && r_ready) r_step <= s_axis_step.tdata;
        end
    end

    // Phase accumulator, dither LFSR (x^24+x^23+x^22+x^17+1) and sample lookup.
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            r_acc      <= '0;
            r_lfsr     <= LFSR_SEED;
            r_i_sample <= '0;
            r_q_sample <= '0;
        end else if (w_tick) begin
            r_acc      <= r_acc + r_step;
            r_lfsr     <= {r_lfsr[LFSR_WIDTH-2:0], r_lfsr[23] ^ r_lfsr[22] ^ r_lfsr[21] ^ r_lfsr[16]};
            r_i_sample <= w_lut[w_i_idx];
            r_q_sample <= w_lut[w_q_idx];
        end
    end

    mod1_dsm #(.WIDTH(WIDTH), .EXT(EXT), .IN_SHIFT(IN_SHIFT)) u_mod_i (
        .aclk     (aclk),
        .arst_n   (arst_n),
        .i_en     (w_tick),
        .i_sample (r_i_sample),
        .o_bit    (w_i_bit)
    );

    mod1_dsm #(.WIDTH(WIDTH), .EXT(EXT), .IN_SHIFT(IN_SHIFT)) u_mod_q (
        .aclk     (aclk),
        .arst_n   (arst_n),
        .i_en     (w_tick),
        .i_sample (r_q_sample),
        .o_bit    (w_q_bit)
    );

    // fs/4 mixer; bits only change on the tick edge, so each frame sees one I/Q pair.
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            r_data_out <= 1'b0;
        end else begin
            case (r_cnt)
                2'd0:    r_data_out <= w_i_bit;
                2'd1:    r_data_out <= w_q_bit;
                2'd2:    r_data_out <= ~w_i_bit;
                default: r_data_out <= ~w_q_bit;
            endcase
        end
    end

    assign s_axis_step.tready = r_ready;
    assign i_sample           = r_i_sample;
    assign q_sample           = r_q_sample;
    assign i_bit              = w_i_bit;
    assign q_bit              = w_q_bit;
    assign data_out           = r_data_out;
endmodule

// File: tb/tb_iq_dsm_upconverter.sv
// Bench for iq_dsm_upconverter: a tick-level NCO/modulator reference model checks
// every cycle, plus directed vector table, density, ramp and reset sequences.
module tb_iq_dsm_upconverter;
    localparam int D = 256;

    logic aclk = 1'b0;
    logic arst_n;
    logic dither_enable;
    logic signed [15:0] i_sample;
    logic signed [15:0] q_sample;
    logic i_bit;
    logic q_bit;
    logic data_out;

    always #5 aclk = ~aclk;

    iq_dsm_upconverter_if #(.ACC_WIDTH(32)) step_if ();

    iq_dsm_upconverter dut (
        .aclk          (aclk),
        .arst_n        (arst_n),
        .s_axis_step   (step_if),
        .dither_enable (dither_enable),
        .i_sample      (i_sample),
        .q_sample      (q_sample),
        .i_bit         (i_bit),
        .q_bit         (q_bit),
        .data_out      (data_out)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int lut [D];

    // Reference model state (tick granularity, plain integer arithmetic).
    int          m_ph;
    bit          m_rdy;
    logic [31:0] m_step;
    logic [31:0] m_acc;
    logic [23:0] m_lfsr;
    int          m_si;
    int          m_sq;
    longint      m_vi;
    longint      m_vq;
    bit          m_bi;
    bit          m_bq;
    bit          m_do;
    int          n_ticks;
    int          fo;
    int          fl;

    typedef struct {
        logic [31:0] step;
        bit          dith;
        int          ticks;
        int          exp_i;
        int          exp_q;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_rdy = 0; m_step = 0; m_acc = 0; m_lfsr = 24'h000001;
        m_si = 0; m_sq = 0; m_vi = 0; m_vq = 0; m_bi = 0; m_bq = 0; m_do = 0;
        n_ticks = 0; fo = 0; fl = 0;
    endtask

    // One clock: capture inputs, advance model, then check every output 1 time unit later.
    task automatic cyc();
        bit          rs;
        bit          tv;
        bit          de;
        logic [31:0] td;
        logic [31:0] ph;
        int          qi;
        int          nsi;
        int          nsq;
        int          c;
        rs = arst_n; tv = step_if.tvalid; td = step_if.tdata; de = dither_enable;
        c  = -1;
        @(posedge aclk);
        if (!rs) begin
            model_reset();
        end else begin
            c = m_ph;
            case (m_ph)
                0:       m_do = m_bi;
                1:       m_do = m_bq;
                2:       m_do = !m_bi;
                default: m_do = !m_bq;
            endcase
            if (m_ph == 3) begin
                ph  = m_acc + (de ? {8'h00, m_lfsr} : 32'h0);
                qi  = int'(ph[31:24]);
                nsq = lut[qi];
                nsi = lut[(qi + 64) % D];
                m_bi = (m_vi >= 0);
                m_vi = m_vi + longint'(m_si >>> 2) - (m_bi ? 64'sd32768 : -64'sd32768);
                m_bq = (m_vq >= 0);
                m_vq = m_vq + longint'(m_sq >>> 2) - (m_bq ? 64'sd32768 : -64'sd32768);
                m_si = nsi;
                m_sq = nsq;
                m_acc  = m_acc + m_step;
                m_lfsr = {m_lfsr[22:0], m_lfsr[23] ^ m_lfsr[22] ^ m_lfsr[21] ^ m_lfsr[16]};
                n_ticks++;
            end
            if (tv && m_rdy) m_step = td;
            m_rdy = 1;
            m_ph  = (m_ph + 1) % 4;
        end
        #1;
        chk("tready", step_if.tready, m_rdy);
        chk("i_sample", i_sample, m_si);
        chk("q_sample", q_sample, m_sq);
        chk("i_bit", i_bit, m_bi);
        chk("q_bit", q_bit, m_bq);
        chk("data_out", data_out, m_do);
        if (c >= 0) begin
            if (c == 0) begin fo = 0; fl = 0; end
            fo += int'(data_out);
            fl++;
            if (c == 3 && fl == 4) chk("frame_ones", fo, 2);
        end
    endtask

    task automatic run_ticks(input int n);
        int target;
        target = n_ticks + n;
        while (n_ticks < target) cyc();
    endtask

    task automatic do_reset(input int ncyc);
        arst_n = 1'b0;
        for (int k = 0; k < ncyc; k++) cyc();
        arst_n = 1'b1;
    endtask

    task automatic load_step(input logic [31:0] v);
        bit rd;
        int guard;
        guard = 0;
        step_if.tvalid = 1'b1;
        step_if.tdata  = v;
        do begin
            rd = step_if.tready;
            cyc();
            guard++;
        end while (!rd && guard < 10);
        if (!rd) chk("step_accept_timeout", 0, 1);
        step_if.tvalid = 1'b0;
    endtask

    initial begin
        int ones_i;
        int ones_q;
        int viol;
        int prev_q;
        real x;

        for (int k = 0; k < D; k++) begin
            x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * $itor(k) / $itor(D));
            lut[k] = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
        end

        vecs[0] = '{32'h0000_0000, 1'b0, 3, 32767, 0};
        vecs[1] = '{32'h4000_0000, 1'b0, 2, 0, 32767};
        vecs[2] = '{32'h4000_0000, 1'b0, 3, -32767, 0};
        vecs[3] = '{32'h4000_0000, 1'b0, 4, 0, -32767};
        vecs[4] = '{32'h8000_0000, 1'b0, 2, -32767, 0};
        vecs[5] = '{32'h2000_0000, 1'b0, 2, 23170, 23170};
        vecs[6] = '{32'h2000_0000, 1'b0, 4, -23170, 23170};
        vecs[7] = '{32'h0000_0000, 1'b1, 5, 32767, 0};

        model_reset();
        arst_n = 1'b0; dither_enable = 1'b0;
        step_if.tvalid = 1'b0; step_if.tdata = '0;

        // Long reset, then tready one cycle after release.
        for (int k = 0; k < 10; k++) cyc();
        chk("rst_tready", step_if.tready, 0);
        chk("rst_data_out", data_out, 0);
        arst_n = 1'b1;
        cyc();
        chk("release_tready", step_if.tready, 1);

        // Directed vector table, each from a fresh reset.
        for (int v = 0; v < 8; v++) begin
            dither_enable = vecs[v].dith;
            do_reset(2);
            load_step(vecs[v].step);
            run_ticks(vecs[v].ticks - n_ticks);
            chk($sformatf("vec%0d_i", v), i_sample, vecs[v].exp_i);
            chk($sformatf("vec%0d_q", v), q_sample, vecs[v].exp_q);
        end
        dither_enable = 1'b0;

        // Constant inputs: bit densities 0.625 (I) and 0.5 (Q).
        do_reset(2);
        load_step(32'h0);
        run_ticks(8);
        ones_i = 0; ones_q = 0;
        for (int k = 0; k < 1024; k++) begin
            run_ticks(1);
            ones_i += int'(i_bit);
            ones_q += int'(q_bit);
        end
        chk_range("i_bit_density", ones_i, 639, 641);
        chk_range("q_bit_density", ones_q, 511, 513);

        // Slow ramp: q rises monotonically to full scale after 4096 ticks + 1 latency.
        do_reset(2);
        load_step(32'h0004_0000);
        viol = 0; prev_q = -40000;
        while (n_ticks < 4096) begin
            run_ticks(1);
            if (int'(q_sample) < prev_q) viol++;
            prev_q = int'(q_sample);
        end
        chk("ramp_q_below_peak", (int'(q_sample) < 32767) ? 1 : 0, 1);
        run_ticks(1);
        chk("ramp_q_peak", q_sample, 32767);
        chk("ramp_monotonic_violations", viol, 0);

        // One-cycle reset mid-sine, then restart from phase 0.
        do_reset(2);
        load_step(32'h2000_0000);
        run_ticks(6);
        cyc(); cyc();
        arst_n = 1'b0;
        cyc();
        chk("midrst_i", i_sample, 0);
        chk("midrst_q", q_sample, 0);
        chk("midrst_data_out", data_out, 0);
        chk("midrst_tready", step_if.tready, 0);
        arst_n = 1'b1;
        load_step(32'h2000_0000);
        run_ticks(1 - n_ticks);
        chk("resume_i", i_sample, 32767);
        chk("resume_q", q_sample, 0);

        // Random steps, handshakes, dither toggles and one reset pulse.
        do_reset(2);
        for (int k = 0; k < 3000; k++) begin
            step_if.tvalid = ($urandom_range(0, 7) == 0);
            step_if.tdata  = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom >> 8);
            if ($urandom_range(0, 63) == 0) dither_enable = ~dither_enable;
            arst_n = (k == 1500) ? 1'b0 : 1'b1;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/iq_dsm_upconverter.md
IQ_DSM_UPCONVERTER -- requirements
Module: iq_dsm_upconverter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: signed NCO sample width.
REQ-002 SHALL have parameter LUT_DEPTH, default 256: sine LUT entries (power of 2); ACC_INT_WIDTH = log2(LUT_DEPTH).
REQ-003 SHALL have parameter ACC_FRAC_WIDTH, default 24: fractional phase bits; ACC_WIDTH = ACC_INT_WIDTH + ACC_FRAC_WIDTH (32 by default).
REQ-004 SHALL have parameter EXT, default 1: extra integrator guard bits in the modulators.
REQ-005 SHALL have parameter IN_SHIFT, default 2: arithmetic right shift applied to NCO samples before modulation.
REQ-006 aclk  in  1  sole clock; all state updates on its rising edge.
REQ-007 arst_n  in  1  reset, synchronous, active-low.
REQ-008 s_axis_step_tdata  in  ACC_WIDTH  phase increment (unsigned).
REQ-009 s_axis_step_tvalid  in  1  step valid.
REQ-010 s_axis_step_tready  out  1  step accept.
REQ-011 dither_enable  in  1  enables phase dither.
REQ-012 i_sample / q_sample  out  WIDTH each  signed cosine / sine NCO samples.
REQ-013 i_bit / q_bit  out  1 each  modulator bitstreams.
REQ-014 data_out  out  1  upconverted serial bit.

Function
REQ-015 A free-running 2-bit phase counter SHALL generate tick = 1 when counter == 3, i.e. one sample tick per 4 aclk cycles.
REQ-016 s_axis_step_tready SHALL be 1 whenever out of reset; on tvalid && tready the step register loads tdata in that cycle.
REQ-017 On each tick, the phase accumulator SHALL add the step register modulo 2^ACC_WIDTH (wrap-around silent).
REQ-018 Dither: when dither_enable = 1, a 24-bit maximal LFSR (advanced every tick) SHALL be added to the fractional bits of the lookup phase only; the accumulator itself is never dithered.
REQ-019 Q index = phase[ACC_WIDTH-1 -: ACC_INT_WIDTH]; I index = Q index + LUT_DEPTH/4 (mod LUT_DEPTH), giving cosine.
REQ-020 LUT entry k SHALL equal round((2^(WIDTH-1)-1)*sin(2*pi*k/LUT_DEPTH)); no interpolation.
REQ-021 i_sample/q_sample SHALL be registered and update on the tick after the accumulator update (1-tick lookup latency).
REQ-022 Each first-order modulator: x = sample >>> IN_SHIFT; y = 1 when integrator v >= 0, else 0; on tick v <= v + x - (y ? 2^(WIDTH-1) : -2^(WIDTH-1)); v width WIDTH+1+EXT signed, never saturates for |x| < 2^(WIDTH-1).
REQ-023 i_bit/q_bit SHALL be registered y values, updated on tick, 1 tick after the sample they represent.
REQ-024 Upconverter: data_out SHALL be registered every aclk cycle from counter value c: c=0 -> i_bit, c=1 -> q_bit, c=2 -> ~i_bit, c=3 -> ~q_bit (fs/4 carrier, I/Q/-I/-Q).
REQ-025 Each 4-cycle frame aligned to c=0 SHALL use i_bit/q_bit values held constant across the frame (bits update only at the frame boundary).

Reset
REQ-026 While arst_n = 0 at a rising edge: counter, step register, accumulator, LFSR (to nonzero seed 24'h000001), samples, integrators, bits and data_out SHALL clear to 0; tready = 0.
REQ-027 Reset mid-operation SHALL take effect at the next edge with no partial frame continued; first tick after release occurs on the 4th edge.

Structure
REQ-028 A shared package SHALL hold WIDTH/LUT_DEPTH/ACC_FRAC_WIDTH defaults, ACC_WIDTH and the quarter-turn offset constant.
REQ-029 The first-order modulator SHALL be one sub-module, mod1_dsm, instantiated twice (I and Q); NCO and upconverter logic stay in the top.

Verification
REQ-030 Reset: hold arst_n=0 10 cycles -> all outputs 0, tready 0; release -> tready 1 next cycle.
REQ-031 step=0, dither off -> i_sample = 32767, q_sample = 0 after 2 ticks.
REQ-032 step=1<<18 -> q_sample rises monotonically and reaches 32767 at tick 4096 (+1 latency); full period 16384 ticks, wrap without glitch.
REQ-033 step=0 (x_I = 8191, x_Q = 0) -> over 1024 ticks i_bit has 640 +/-1 ones, q_bit 512 +/-1.
REQ-034 Any stimulus -> every frame of data_out equals {i_bit, q_bit, ~i_bit, ~q_bit} and has exactly 2 ones.
REQ-035 Assert arst_n=0 for one cycle mid-sine -> next cycle outputs 0; operation resumes from phase 0.
